pcm_iis_tx: RTL



---
 rtl/pcm_iis_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pcm_iis_tx.sv
// pcm_iis_tx: I2S master transmitter, double-buffered, MSB-first serialiser.
// Optional feature macro: UNDERRUN_REPEAT_EN (repeat last pair on underrun).
//
// Ports:
//   bclk         bit clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   in_l, in_r   left/right PCM samples (two's complement, SAMPLE_W bits)
//   in_valid     in_l/in_r valid
//   in_ready     holding register empty; transfer on in_valid && in_ready
//   ws           word select, 0 = left, 1 = right, I2S one-bit delay
//   sd           serial data, MSB first
//   frame_start  one-cycle pulse while cnt == 0
//   underrun     one-cycle pulse when a frame starts with no sample held
//   underrun_cnt saturating underrun count
module pcm_iis_tx #(
    parameter int SLOT_W   = 32,
    parameter int SAMPLE_W = 24
) (
    input  logic                bclk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] in_l,
    input  logic [SAMPLE_W-1:0] in_r,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                ws,
    output logic                sd,
    output logic                frame_start,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CW      = $clog2(FRAME_W);

    localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] WS_HI_FROM = CW'(SLOT_W - 1);
    localparam logic [CW-1:0] WS_HI_TO   = CW'(FRAME_W - 2);

    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                wrap;
    logic                ws_nxt;
    logic                take;
    logic [FRAME_W-1:0]  shift;
    logic [FRAME_W-1:0]  hold_frame;
    logic [FRAME_W-1:0]  fill_frame;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic                hold_full;

    // Left-justify a sample in its slot; unused LSBs are sent as zero.
    function automatic logic [SLOT_W-1:0] pad(input logic [SAMPLE_W-1:0] s);
        logic [SLOT_W-1:0] t;
        t = '0;
        t[SLOT_W-1 -: SAMPLE_W] = s;
        return t;
    endfunction

    assign wrap     = (cnt == CNT_LAST);
    assign cnt_nxt  = wrap ? '0 : cnt + 1'b1;
    assign take     = in_valid && !hold_full;
    assign in_ready = !hold_full;
    assign sd       = shift[FRAME_W-1];

    // ws is registered from the next count value so it leads each slot
    // MSB by one bit, as I2S requires.
    assign ws_nxt = (cnt_nxt >= WS_HI_FROM) && (cnt_nxt <= WS_HI_TO);

    assign hold_frame = {pad(hold_l), pad(hold_r)};

`ifdef UNDERRUN_REPEAT_EN
    logic [SAMPLE_W-1:0] last_l;
    logic [SAMPLE_W-1:0] last_r;

    assign fill_frame = {pad(last_l), pad(last_r)};

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            last_l <= '0;
            last_r <= '0;
        end else if (wrap && hold_full) begin
            last_l <= hold_l;
            last_r <= hold_r;
        end
    end
`else
    assign fill_frame = '0;
`endif

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            ws          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            ws          <= ws_nxt;
            frame_start <= wrap;
            underrun    <= wrap && !hold_full;
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else if (wrap) begin
            shift <= hold_full ? hold_frame : fill_frame;
        end else begin
            shift <= {shift[FRAME_W-2:0], 1'b0};
        end
    end

    // A transfer on the wrap edge with the holding register empty is kept
    // for the following frame; the current frame is still an underrun.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
        end else if (take) begin
            hold_l    <= in_l;
            hold_r    <= in_r;
            hold_full <= 1'b1;
        end else if (wrap) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (wrap && !hold_full && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

endmodule
